// File: rtl/piso.sv
// rtl/piso.sv - parallel-in/serial-out converter for the PMA transmit path
// One-deep holding register feeds a shift register; bits leave LSB first.
module piso #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_code_group,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             serial,
  output logic             code_start,
  output logic             tx_underflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             code_start_q, code_start_d;
  logic             underflow_q, underflow_d;
  logic             take;
  logic             load;

  assign tx_ready     = reset & ~hold_full_q;
  assign take         = tx_valid & tx_ready;
  assign serial       = shift_q[0];
  assign code_start   = code_start_q;
  assign tx_underflow = underflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_data_q  <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      code_start_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      code_start_q <= code_start_d;
      underflow_q  <= underflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    code_start_d = 1'b0;
    underflow_d  = 1'b0;
    load         = 1'b0;

    // A write needs an empty hold and a load needs a full one, so they never collide.
    if (take) begin
      hold_data_d = tx_code_group;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt_q != LAST) begin
          shift_d   = {1'b0, shift_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + CW'(1);
        end else if (hold_full_q) begin
          load = 1'b1;
        end else begin
          shift_d     = '0;
          state_d     = IDLE;
          underflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d      = hold_data_q;
      hold_full_d  = 1'b0;
      bit_cnt_d    = '0;
      code_start_d = 1'b1;
      state_d      = SHIFT;
    end
  end

endmodule

// File: tb/tb_piso.sv
// tb/tb_piso.sv - self-checking bench for piso
module tb_piso;

  logic       clk;
  logic       reset;
  logic [9:0] tx_code_group;
  logic       tx_valid;
  logic       tx_ready;
  logic       serial;
  logic       code_start;
  logic       tx_underflow;

  int checks = 0;
  int errors = 0;

  piso #(.WIDTH(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_code_group(tx_code_group),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .serial       (serial),
    .code_start   (code_start),
    .tx_underflow (tx_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [9:0] data;
    logic       ser;
    logic       cs;
    logic       uf;
    logic       rdy;
  } row_t;

  row_t rows[$];

  // Transmission order of 10'h2B1 and 10'h17C, first bit in the MSB position.
  localparam logic [9:0] SEQ_A = 10'b1000110101;
  localparam logic [9:0] SEQ_B = 10'b0011111010;

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [9:0] d, input logic s,
                     input logic c, input logic u, input logic r);
    row_t x;
    x.valid = v; x.data = d; x.ser = s; x.cs = c; x.uf = u; x.rdy = r;
    rows.push_back(x);
  endtask

  // Rows for one code-group leaving the line; the hold is empty throughout.
  task automatic add_bits(input logic [9:0] seq);
    for (int i = 0; i < 10; i++) add(1'b0, 10'h0, seq[9-i], i == 0, 1'b0, 1'b1);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < rows.size(); i++) begin
      tx_valid      = rows[i].valid;
      tx_code_group = rows[i].data;
      @(posedge clk);
      @(negedge clk);
      chk({name, ".serial"},     i, serial,       rows[i].ser);
      chk({name, ".code_start"}, i, code_start,   rows[i].cs);
      chk({name, ".underflow"},  i, tx_underflow, rows[i].uf);
      chk({name, ".ready"},      i, tx_ready,     rows[i].rdy);
    end
    tx_valid = 1'b0;
    rows.delete();
  endtask

  initial begin
    reset         = 1'b0;
    tx_valid      = 1'b1;
    tx_code_group = 10'h2B1;

    // Held in reset with valid asserted: nothing moves, nothing is accepted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.serial", 0, serial, 1'b0);
    chk("rst.code_start", 0, code_start, 1'b0);
    chk("rst.underflow", 0, tx_underflow, 1'b0);
    chk("rst.ready", 0, tx_ready, 1'b0);
    tx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rst.ready_release", 0, tx_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.idle_serial", i, serial, 1'b0);
      chk("rst.idle_cs", i, code_start, 1'b0);
    end

    // Single code-group from idle.
    add(1'b1, 10'h2B1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(SEQ_A);
    add(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_table("single");

    // Back-to-back with backpressure junk offered whenever the hold is full.
    add(1'b1, 10'h2B1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 10'h3FF, SEQ_A[9], 1'b1, 1'b0, 1'b1);
    add(1'b1, 10'h17C, SEQ_A[8], 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 10; i++)
      add(1'b1, (i % 2) ? 10'h155 : 10'h0AA, SEQ_A[9-i], 1'b0, 1'b0, 1'b0);
    add(1'b1, 10'h3FF, SEQ_B[9], 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 10; i++) add(1'b0, 10'h0, SEQ_B[9-i], 1'b0, 1'b0, 1'b1);
    add(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_table("b2b");

    // Late refill: second write lands on the last-bit edge, one idle bit follows.
    add(1'b1, 10'h2B1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(SEQ_A);
    add(1'b1, 10'h17C, 1'b0, 1'b0, 1'b1, 1'b0);
    add_bits(SEQ_B);
    add(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_table("late");

    // Reset mid-stream: bit 4 of 10'h2B1 on the line with 10'h17C held.
    add(1'b1, 10'h2B1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 10'h0, SEQ_A[9], 1'b1, 1'b0, 1'b1);
    add(1'b1, 10'h17C, SEQ_A[8], 1'b0, 1'b0, 1'b0);
    add(1'b0, 10'h0, SEQ_A[7], 1'b0, 1'b0, 1'b0);
    add(1'b0, 10'h0, SEQ_A[6], 1'b0, 1'b0, 1'b0);
    add(1'b0, 10'h0, SEQ_A[5], 1'b0, 1'b0, 1'b0);
    run_table("midrst_pre");
    chk("midrst.serial_before", 0, serial, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst.serial", 0, serial, 1'b0);
    chk("midrst.code_start", 0, code_start, 1'b0);
    chk("midrst.underflow", 0, tx_underflow, 1'b0);
    chk("midrst.ready", 0, tx_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("midrst.post_serial", i, serial, 1'b0);
      chk("midrst.post_uf", i, tx_underflow, 1'b0);
      chk("midrst.post_cs", i, code_start, 1'b0);
    end

    // A fresh write after the reset goes out normally.
    add(1'b1, 10'h17C, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(SEQ_B);
    add(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_table("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
